// File: rtl/srcnn_row_addr_gen.sv
// Raster-order tile address sequencer feeding the row*stride multiplier; one MUL bubble per row.
// Optional sticky overflow detection under `SRCNN_ADDR_GEN_OVF_CHECK_EN (default: addr_ovf tied 0).
module srcnn_row_addr_gen #(
    parameter int ROW_W    = 7,
    parameter int STRIDE_W = 10,
    parameter int COL_W    = 10,
    parameter int ADDR_W   = 15
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_idle,
    output logic                ap_done,
    input  logic [ROW_W-1:0]    cfg_rows,
    input  logic [COL_W-1:0]    cfg_cols,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic [ADDR_W-1:0]   cfg_base,
    output logic [ROW_W-1:0]    mul_din0,
    output logic [STRIDE_W-1:0] mul_din1,
    input  logic [ADDR_W-1:0]   mul_dout,
    output logic [ADDR_W-1:0]   addr_out,
    output logic                addr_valid,
    input  logic                addr_ready,
    output logic                addr_last,
    output logic                addr_ovf
);

`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
    localparam int SUM_W = ADDR_W + 2;
`else
    localparam int SUM_W = ADDR_W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_EMIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    rows_q, rows_d, row_q, row_d;
    logic [COL_W-1:0]    cols_q, cols_d, col_q, col_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0]   base_q, base_d, row_base_q, row_base_d, addr_q, addr_d;
    logic                valid_q, valid_d, last_q, last_d;

    logic [ADDR_W-1:0]   rb_sel;
    logic [COL_W-1:0]    col_sel;
    logic [SUM_W-1:0]    sum_w;
    logic                last_nxt;

    // Next address is always computed one step ahead so addr_out can be a register.
    assign rb_sel   = (state_q == S_MUL) ? mul_dout : row_base_q;
    assign col_sel  = (state_q == S_MUL) ? '0 : col_q + COL_W'(1);
    assign sum_w    = SUM_W'(base_q) + SUM_W'(rb_sel) + SUM_W'(col_sel);
    assign last_nxt = (row_q == rows_q - ROW_W'(1)) && (col_sel == cols_q - COL_W'(1));

`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
    logic [ROW_W+STRIDE_W-1:0] prod_full;
    logic                      carry_w, prod_ovf;
    logic                      ovf_q, ovf_d;
    assign prod_full = (ROW_W+STRIDE_W)'(row_q) * (ROW_W+STRIDE_W)'(stride_q);
    assign prod_ovf  = (prod_full[ROW_W+STRIDE_W-1:ADDR_W] != '0);
    assign carry_w   = (sum_w[SUM_W-1:ADDR_W] != '0);
    assign addr_ovf  = ovf_q;
`else
    assign addr_ovf  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        stride_d   = stride_q;
        base_d     = base_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        last_d     = last_q;
`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
        ovf_d      = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    rows_d   = cfg_rows;
                    cols_d   = cfg_cols;
                    stride_d = cfg_stride;
                    base_d   = cfg_base;
                    row_d    = '0;
                    col_d    = '0;
`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = (cfg_rows == '0 || cfg_cols == '0) ? S_DONE : S_MUL;
                end
            end
            S_MUL: begin
                row_base_d = mul_dout;
                addr_d     = sum_w[ADDR_W-1:0];
                last_d     = last_nxt;
                valid_d    = 1'b1;
`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
                ovf_d      = ovf_q | prod_ovf | carry_w;
`endif
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (valid_q && addr_ready) begin
                    if (col_q < cols_q - COL_W'(1)) begin
                        col_d  = col_q + COL_W'(1);
                        addr_d = sum_w[ADDR_W-1:0];
                        last_d = last_nxt;
`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
                        ovf_d  = ovf_q | carry_w;
`endif
                    end else begin
                        col_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (row_q < rows_q - ROW_W'(1)) begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = S_MUL;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            stride_q   <= '0;
            base_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            stride_q   <= stride_d;
            base_q     <= base_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign ap_idle    = (state_q == S_IDLE);
    assign ap_done    = (state_q == S_DONE);
    assign mul_din0   = row_q;
    assign mul_din1   = stride_q;
    assign addr_out   = addr_q;
    assign addr_valid = valid_q;
    assign addr_last  = last_q;

endmodule

// File: tb/tb_srcnn_row_addr_gen.sv
// Scoreboard bench for srcnn_row_addr_gen: directed tiles, ready patterns, reset mid-tile.
module tb_srcnn_row_addr_gen;

    logic        ap_clk, ap_rst_n, ap_start, ap_idle, ap_done;
    logic [6:0]  cfg_rows;
    logic [9:0]  cfg_cols, cfg_stride;
    logic [14:0] cfg_base;
    logic [6:0]  mul_din0;
    logic [9:0]  mul_din1;
    logic [14:0] mul_dout, addr_out;
    logic        addr_valid, addr_ready, addr_last, addr_ovf;

`ifdef SRCNN_ADDR_GEN_OVF_CHECK_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    srcnn_row_addr_gen dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
        .ap_done(ap_done), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_stride(cfg_stride), .cfg_base(cfg_base), .mul_din0(mul_din0),
        .mul_din1(mul_din1), .mul_dout(mul_dout), .addr_out(addr_out),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_last(addr_last),
        .addr_ovf(addr_ovf)
    );

    // Combinational multiplier model, truncated to 15 bits.
    assign mul_dout = 15'({8'b0, mul_din0} * {5'b0, mul_din1});

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    typedef struct packed {
        logic [14:0] a;
        logic        l;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          last_acc_cyc = -1;
    int          mul_row = 0;
    logic [9:0]  cur_stride = '0;
    int          ready_mode = 0;
    logic        prev_stall = 1'b0;
    logic [14:0] prev_addr = '0;
    logic        prev_last = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ready pattern: 0 = always, 1 = alternating, 2 = random.
    initial begin
        addr_ready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            case (ready_mode)
                1:       addr_ready = ~addr_ready;
                2:       addr_ready = 1'($urandom_range(0, 1));
                default: addr_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pop on transfer, stall stability, MUL-cycle operand check.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(addr_valid), 32'd1);
                chk("hold_addr", 32'(addr_out), 32'(prev_addr));
                chk("hold_last", 32'(addr_last), 32'(prev_last));
            end
            if (addr_valid && addr_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_addr", 32'(addr_out), 32'h7fffffff);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("addr", 32'(addr_out), 32'(e.a));
                    chk("last", 32'(addr_last), 32'(e.l));
                    if (addr_last) last_acc_cyc = cyc;
                end
            end
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = addr_out;
            prev_last  = addr_last;
            if (ap_idle && ap_start) begin
                mul_row = 0;
            end else if (!ap_idle && !ap_done && !addr_valid) begin
                chk("mul_din0", 32'(mul_din0), 32'(mul_row));
                chk("mul_din1", 32'(mul_din1), 32'(cur_stride));
                mul_row++;
            end
        end
    end

    task automatic push(input logic [14:0] a, input logic l);
        exp_t e;
        e.a = a;
        e.l = l;
        q.push_back(e);
    endtask

    task automatic push_t1();
        push(15'd0, 1'b0); push(15'd1, 1'b0); push(15'd2, 1'b0);
        push(15'd100, 1'b0); push(15'd101, 1'b0); push(15'd102, 1'b1);
    endtask

    task automatic start_tile(input logic [6:0] r, input logic [9:0] c,
                              input logic [9:0] s, input logic [14:0] b);
        @(posedge ap_clk);
        #1;
        cfg_rows   = r;
        cfg_cols   = c;
        cfg_stride = s;
        cfg_base   = b;
        cur_stride = s;
        ap_start   = 1'b1;
        start_cyc  = cyc;
        @(posedge ap_clk);
        #1;
        ap_start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        if (!seen) begin
            chk({name, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            @(negedge ap_clk);
            chk({name, "_done_pulse"}, 32'(ap_done), 32'd0);
            chk({name, "_idle_after"}, 32'(ap_idle), 32'd1);
        end
        chk({name, "_queue_empty"}, 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_idle"}, 32'(ap_idle), 32'd1);
        chk({name, "_done"}, 32'(ap_done), 32'd0);
        chk({name, "_valid"}, 32'(addr_valid), 32'd0);
        chk({name, "_last"}, 32'(addr_last), 32'd0);
        chk({name, "_ovf"}, 32'(addr_ovf), 32'd0);
        chk({name, "_addr"}, 32'(addr_out), 32'd0);
        chk({name, "_din0"}, 32'(mul_din0), 32'd0);
        chk({name, "_din1"}, 32'(mul_din1), 32'd0);
    endtask

    initial begin
        int  dcyc;
        bit  hit;
        ap_rst_n   = 1'b1;
        ap_start   = 1'b0;
        cfg_rows   = '0;
        cfg_cols   = '0;
        cfg_stride = '0;
        cfg_base   = '0;
        #2 ap_rst_n = 1'b0;
        #1 check_reset("rst");
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // 1: basic 2x3 tile, ready held high
        ready_mode = 0;
        push_t1();
        start_tile(7'd2, 10'd3, 10'd100, 15'd0);
        wait_done("t1", 40, dcyc);
        chk("t1_done_after_last", 32'(dcyc), 32'(last_acc_cyc + 1));
        chk("t1_total_cycles", 32'(dcyc), 32'(start_cyc + 9));
        chk("t1_ovf", 32'(addr_ovf), 32'd0);

        // 2: alternating ready plus an ignored busy start with changed cfg
        ready_mode = 1;
        push_t1();
        start_tile(7'd2, 10'd3, 10'd100, 15'd0);
        repeat (2) @(posedge ap_clk);
        #1;
        cfg_rows = 7'd5; cfg_cols = 10'd7; cfg_stride = 10'd9; cfg_base = 15'h1234;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        wait_done("t2a", 60, dcyc);

        ready_mode = 2;
        push_t1();
        start_tile(7'd2, 10'd3, 10'd100, 15'd0);
        wait_done("t2b", 200, dcyc);
        ready_mode = 0;

        // 3: empty tiles
        start_tile(7'd0, 10'd3, 10'd100, 15'd0);
        wait_done("t3r", 10, dcyc);
        chk("t3r_done_lat", 32'(dcyc), 32'(start_cyc + 1));
        start_tile(7'd2, 10'd0, 10'd100, 15'd0);
        wait_done("t3c", 10, dcyc);
        chk("t3c_done_lat", 32'(dcyc), 32'(start_cyc + 1));

        // 4: base near top of address space wraps
        push(15'h7ffe, 1'b0); push(15'h7fff, 1'b0); push(15'h0000, 1'b1);
        start_tile(7'd1, 10'd3, 10'd0, 15'h7ffe);
        wait_done("t4", 20, dcyc);
        chk("t4_ovf", 32'(addr_ovf), 32'(EXP_OVF));

        // 5: max rows and stride, one column per row
        for (int r = 0; r < 127; r++)
            push(15'((r * 1023) % 32768), (r == 126));
        start_tile(7'd127, 10'd1, 10'd1023, 15'd0);
        wait_done("t5", 400, dcyc);
        chk("t5_mul_cycles", 32'(mul_row), 32'd127);
        chk("t5_ovf", 32'(addr_ovf), 32'(EXP_OVF));

        // 6: reset during row 1 col 1, then full restart
        push_t1();
        start_tile(7'd2, 10'd3, 10'd100, 15'd0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (addr_valid && addr_out == 15'd101) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t6_reached_r1c1", 32'(hit), 32'd1);
        #2 ap_rst_n = 1'b0;
        #1 check_reset("t6_rst");
        q.delete();
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        push_t1();
        start_tile(7'd2, 10'd3, 10'd100, 15'd0);
        wait_done("t6", 40, dcyc);
        chk("t6_total_cycles", 32'(dcyc), 32'(start_cyc + 9));
        chk("t6_ovf", 32'(addr_ovf), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
